// File: rtl/fft_feeder_pkg.sv
// fft_feeder_pkg
// Shared definitions for the FFT frame feeder:
//   clog2()     - address-width helper for the N-point frame buffer
//   rd_state_t  - read-side burst FSM state
//   sample_t    - one complex sample {re, im} at the default component width
package fft_feeder_pkg;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } rd_state_t;

   localparam int SMP_W = 16;

   typedef struct packed {
      logic [SMP_W-1:0] re;
      logic [SMP_W-1:0] im;
   } sample_t;

endpackage

// File: rtl/fft_pingpong_ram.sv
// fft_pingpong_ram
// Simple dual-port RAM holding both ping-pong banks (bank select is the address MSB).
// Synchronous read with a registered, resettable read port that holds its value
// while i_re is low.
//   clock, reset      clock / async active-low reset (read register only)
//   i_we, i_waddr, i_wdata   write port
//   i_re, i_raddr, o_rdata   read port, data valid one edge after i_re
module fft_pingpong_ram #(
   parameter int DW = 32,
   parameter int AW = 7
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);

   logic [DW-1:0] r_mem [0:(1<<AW)-1];
   logic [DW-1:0] r_rdata;

   always_ff @(posedge clock) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)    r_rdata <= '0;
      else if (i_re) r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/fft_frame_feeder.sv
// fft_frame_feeder
// Collects a gappy valid/ready sample stream into whole N-sample frames in a
// ping-pong buffer and bursts each frame to a pipelined FFT with di_en held for
// N consecutive cycles. Registers the FFT output, tags frame boundaries, counts
// frames and flags a do_en drop inside a frame.
//   clock, reset                       clock / async active-low reset
//   in_valid, in_ready, in_re, in_im   sample input handshake
//   di_en, di_re, di_im                FFT input burst
//   do_en, do_re, do_im                FFT output
//   out_valid, out_re, out_im          do_* delayed one register
//   out_first, out_last                sample 0 / N-1 of an output frame
//   frame_count, err_gap               completed frames / sticky mid-frame gap
//
// Read FSM
//   state    | meaning
//   ST_IDLE  | no frame being sent; wait for full[rb]
//   ST_BURST | reading bank rb at raddr, one entry per cycle
module fft_frame_feeder import fft_feeder_pkg::*; #(
   parameter int WIDTH = 16,
   parameter int N     = 64,
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_re,
   input  logic [WIDTH-1:0] in_im,
   output logic             di_en,
   output logic [WIDTH-1:0] di_re,
   output logic [WIDTH-1:0] di_im,
   input  logic             do_en,
   input  logic [WIDTH-1:0] do_re,
   input  logic [WIDTH-1:0] do_im,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_re,
   output logic [WIDTH-1:0] out_im,
   output logic             out_first,
   output logic             out_last,
   output logic [CNT_W-1:0] frame_count,
   output logic             err_gap
);

   localparam int AW = clog2(N);

   logic [AW-1:0]      r_waddr, r_raddr, r_ocnt;
   logic               r_wb, r_rb;
   logic [1:0]         r_full, w_full_nxt;
   rd_state_t          r_state, w_state_nxt;
   logic               w_accept, w_wlast, w_rlast, w_rd_en, w_free_wb;
   logic               r_di_en;
   logic [2*WIDTH-1:0] w_rdata;
   logic               r_out_valid, r_out_first, r_out_last, r_err_gap;
   logic [WIDTH-1:0]   r_out_re, r_out_im;
   logic [CNT_W-1:0]   r_frame_count;

   // The bank being read is released while its last entry is read; the writer
   // may already put sample 0 of the next frame into it on that edge (different
   // address), so three back-to-back frames never stall the source.
   assign w_rlast   = (r_state == ST_BURST) && (r_raddr == AW'(N-1));
   assign w_free_wb = w_rlast && (r_rb == r_wb);
   assign in_ready  = !r_full[r_wb] || w_free_wb;
   assign w_accept  = in_valid && in_ready;
   assign w_wlast   = w_accept && (r_waddr == AW'(N-1));

   // Write side: waddr wraps to 0 by itself after N-1 because N is a power of two.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_waddr <= '0;
         r_wb    <= 1'b0;
      end else if (w_accept) begin
         r_waddr <= r_waddr + 1'b1;
         if (w_wlast) r_wb <= ~r_wb;
      end
   end

   always_comb begin
      w_full_nxt = r_full;
      if (w_rlast) w_full_nxt[r_rb] = 1'b0;
      if (w_wlast) w_full_nxt[r_wb] = 1'b1;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_full <= 2'b00;
      else        r_full <= w_full_nxt;
   end

   // Read FSM: state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Read FSM: next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (r_full[r_rb]) w_state_nxt = ST_BURST;
         ST_BURST: if (w_rlast && !r_full[~r_rb]) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Read FSM: outputs
   always_comb begin
      w_rd_en = 1'b0;
      if (r_state == ST_BURST) w_rd_en = 1'b1;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_raddr <= '0;
         r_rb    <= 1'b0;
      end else if (w_rd_en) begin
         r_raddr <= r_raddr + 1'b1;
         if (w_rlast) r_rb <= ~r_rb;
      end else begin
         r_raddr <= '0;
      end
   end

   // di_en lines up with the RAM read register, which also holds di_re/di_im
   // between bursts.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_di_en <= 1'b0;
      else        r_di_en <= w_rd_en;
   end

   fft_pingpong_ram #(
      .DW (2*WIDTH),
      .AW (AW+1)
   ) u_ram (
      .clock   (clock),
      .reset   (reset),
      .i_we    (w_accept),
      .i_waddr ({r_wb, r_waddr}),
      .i_wdata ({in_re, in_im}),
      .i_re    (w_rd_en),
      .i_raddr ({r_rb, r_raddr}),
      .o_rdata (w_rdata)
   );

   assign di_en = r_di_en;
   assign di_re = w_rdata[2*WIDTH-1:WIDTH];
   assign di_im = w_rdata[WIDTH-1:0];

   // Output side
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_out_valid   <= 1'b0;
         r_out_re      <= '0;
         r_out_im      <= '0;
         r_out_first   <= 1'b0;
         r_out_last    <= 1'b0;
         r_frame_count <= '0;
         r_err_gap     <= 1'b0;
         r_ocnt        <= '0;
      end else begin
         r_out_valid <= do_en;
         r_out_re    <= do_re;
         r_out_im    <= do_im;
         r_out_first <= do_en && (r_ocnt == '0);
         r_out_last  <= do_en && (r_ocnt == AW'(N-1));
         if (do_en) begin
            r_ocnt <= r_ocnt + 1'b1;
            if (r_ocnt == AW'(N-1)) r_frame_count <= r_frame_count + 1'b1;
         end else if (r_ocnt != '0) begin
            r_err_gap <= 1'b1;
            r_ocnt    <= '0;
         end
      end
   end

   assign out_valid   = r_out_valid;
   assign out_re      = r_out_re;
   assign out_im      = r_out_im;
   assign out_first   = r_out_first;
   assign out_last    = r_out_last;
   assign frame_count = r_frame_count;
   assign err_gap     = r_err_gap;

endmodule

// File: tb/tb_fft_frame_feeder.sv
module tb_fft_frame_feeder;

   localparam int W  = 16;
   localparam int N  = 64;
   localparam int CW = 16;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_re = '0, in_im = '0;
   logic          di_en;
   logic [W-1:0]  di_re, di_im;
   logic          do_en = 1'b0;
   logic [W-1:0]  do_re = '0, do_im = '0;
   logic          out_valid;
   logic [W-1:0]  out_re, out_im;
   logic          out_first, out_last;
   logic [CW-1:0] frame_count;
   logic          err_gap;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   fft_frame_feeder #(.WIDTH(W), .N(N), .CNT_W(CW)) dut (
      .clock       (clock),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_re       (in_re),
      .in_im       (in_im),
      .di_en       (di_en),
      .di_re       (di_re),
      .di_im       (di_im),
      .do_en       (do_en),
      .do_re       (do_re),
      .do_im       (do_im),
      .out_valid   (out_valid),
      .out_re      (out_re),
      .out_im      (out_im),
      .out_first   (out_first),
      .out_last    (out_last),
      .frame_count (frame_count),
      .err_gap     (err_gap)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- input-side model: sample queue + frame schedule ----------
   // A frame whose last sample is accepted on edge a starts its burst on edge
   // max(a+2, end of previous burst + 1) and keeps di_en high for N edges.
   // Its bank counts as holding unsent data until its last entry is read
   // (one edge before its final di_en cycle, i.e. up to edge start+N-3).
   logic [2*W-1:0] exp_q[$];
   int             starts[$];
   int             last_end = -1000;
   int             acc_cnt  = 0;
   int             run_len  = 0;
   int             pending, a_edge, st_edge;
   bit             exp_den;
   logic [2*W-1:0] smp;
   logic [W-1:0]   last_re = '0, last_im = '0;

   // ---------------- output-side model: position within output frame ---------
   int            pos = 0;
   logic          e_ov = 1'b0, e_first = 1'b0, e_last = 1'b0, e_err = 1'b0;
   logic [W-1:0]  e_re = '0, e_im = '0;
   logic [CW-1:0] e_fc = '0;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         pos = 0; e_ov = 0; e_first = 0; e_last = 0; e_err = 0;
         e_re = '0; e_im = '0; e_fc = '0;
      end else begin
         e_ov    = do_en;
         e_re    = do_re;
         e_im    = do_im;
         e_first = do_en && (pos == 0);
         e_last  = do_en && (pos == N-1);
         if (do_en) begin
            if (pos == N-1) e_fc = e_fc + 1'b1;
            pos = (pos + 1) % N;
         end else if (pos != 0) begin
            e_err = 1'b1;
            pos   = 0;
         end
      end
   end

   // ---------------- single compare process ----------------
   always @(negedge clock) begin
      if (!reset) begin
         exp_q.delete();
         starts.delete();
         last_end = -1000; acc_cnt = 0; run_len = 0;
         last_re = '0; last_im = '0;
      end else begin
         while (starts.size() > 0 && starts[0] + N - 1 < cyc) void'(starts.pop_front());
         exp_den = (starts.size() > 0) && (starts[0] <= cyc);
         pending = 0;
         foreach (starts[i]) if (starts[i] + N - 3 > cyc) pending++;
         check("in_ready", 64'(in_ready), 64'(pending < 2));
         check("di_en", 64'(di_en), 64'(exp_den));
         if (di_en) begin
            run_len++;
            if (exp_q.size() == 0) begin
               check("di_queue_nonempty", 64'(exp_q.size()), 64'(1));
            end else begin
               smp = exp_q.pop_front();
               check("di_re", 64'(di_re), 64'(smp[2*W-1:W]));
               check("di_im", 64'(di_im), 64'(smp[W-1:0]));
               last_re = smp[2*W-1:W];
               last_im = smp[W-1:0];
            end
         end else begin
            if (run_len != 0) check("burst_len_mod_n", 64'(run_len % N), 64'(0));
            run_len = 0;
            check("di_re_hold", 64'(di_re), 64'(last_re));
            check("di_im_hold", 64'(di_im), 64'(last_im));
         end
         if (in_valid && in_ready) begin
            exp_q.push_back({in_re, in_im});
            acc_cnt++;
            if (acc_cnt == N) begin
               acc_cnt = 0;
               a_edge  = cyc + 1;
               st_edge = (a_edge + 2 > last_end + 1) ? a_edge + 2 : last_end + 1;
               starts.push_back(st_edge);
               last_end = st_edge + N - 1;
            end
         end
         check("out_valid",   64'(out_valid),   64'(e_ov));
         check("out_re",      64'(out_re),      64'(e_re));
         check("out_im",      64'(out_im),      64'(e_im));
         check("out_first",   64'(out_first),   64'(e_first));
         check("out_last",    64'(out_last),    64'(e_last));
         check("frame_count", 64'(frame_count), 64'(e_fc));
         check("err_gap",     64'(err_gap),     64'(e_err));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic push_sample(input logic [W-1:0] re, input logic [W-1:0] im, input int gap);
      int  guard;
      bit  acc;
      guard = 0;
      while (gap > 0 && $urandom_range(99) < gap) begin
         in_valid = 1'b0;
         @(posedge clock); #1;
      end
      in_valid = 1'b1; in_re = re; in_im = im;
      forever begin
         acc = in_ready;
         @(posedge clock); #1;
         if (acc) break;
         guard++;
         if (guard > 200) begin
            check("accept_timeout", 64'(guard), 64'(0));
            break;
         end
      end
   endtask

   task automatic wait_rise(input string name, input int limit, output int at);
      int g;
      g = 0;
      while (!di_en && g < limit) begin
         @(posedge clock); #1;
         g++;
      end
      check(name, 64'(di_en), 64'(1));
      at = cyc;
   endtask

   task automatic burst_len(output int len);
      len = 0;
      while (di_en && len < 1000) begin
         len++;
         @(posedge clock); #1;
      end
   endtask

   task automatic drive_out(input int n, input int base, output int nf, output int sf,
                            output int nl, output int sl);
      nf = 0; sf = 0; nl = 0; sl = 0;
      for (int i = 0; i < n; i++) begin
         do_en = 1'b1; do_re = W'(base + i); do_im = ~W'(base + i);
         @(posedge clock); #1;
         if (out_first) begin nf++; sf += i; end
         if (out_last)  begin nl++; sl += i; end
      end
      do_en = 1'b0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int a_last, rise, len, nf, sf, nl, sl;

      repeat (3) @(posedge clock);
      #1;
      check("rst_in_ready",    64'(in_ready),    64'(1));
      check("rst_di_en",       64'(di_en),       64'(0));
      check("rst_di_re",       64'(di_re),       64'(0));
      check("rst_di_im",       64'(di_im),       64'(0));
      check("rst_out_valid",   64'(out_valid),   64'(0));
      check("rst_out_first",   64'(out_first),   64'(0));
      check("rst_out_last",    64'(out_last),    64'(0));
      check("rst_out_re",      64'(out_re),      64'(0));
      check("rst_out_im",      64'(out_im),      64'(0));
      check("rst_frame_count", 64'(frame_count), 64'(0));
      check("rst_err_gap",     64'(err_gap),     64'(0));
      reset = 1'b1;
      @(posedge clock); #1;

      // single frame: re = k, im = -k
      for (int k = 0; k < N; k++) push_sample(W'(k), W'(-k), 0);
      in_valid = 1'b0;
      a_last = cyc;
      wait_rise("f1_rise", 20, rise);
      check("f1_latency", 64'(rise - a_last), 64'(2));
      check("f1_first_re", 64'(di_re), 64'(0));
      check("f1_first_im", 64'(di_im), 64'(0));
      @(posedge clock); #1;
      check("f1_second_re", 64'(di_re), 64'(1));
      check("f1_second_im", 64'(di_im), 64'(16'hFFFF));
      burst_len(len);
      check("f1_burst_len", 64'(len + 1), 64'(N));
      repeat (4) @(posedge clock); #1;

      // three back-to-back frames
      fork
         begin
            for (int f = 0; f < 3; f++)
               for (int k = 0; k < N; k++)
                  push_sample(W'(256 + f*N + k), W'(-(256 + f*N + k)), 0);
            in_valid = 1'b0;
         end
         begin
            wait_rise("bb_rise", 400, rise);
            burst_len(len);
            check("bb_burst_len", 64'(len), 64'(3*N));
         end
      join
      repeat (4) @(posedge clock); #1;

      // two frames with ~50 % valid gaps
      for (int f = 0; f < 2; f++)
         for (int k = 0; k < N; k++)
            push_sample(W'(16'h4000 + f*N + k), W'(16'h2000 - k), 50);
      in_valid = 1'b0;
      repeat (N + 10) @(posedge clock); #1;
      check("gap_drained_di_en", 64'(di_en), 64'(0));

      // output path: 128 contiguous do_en
      drive_out(2*N, 16'h0100, nf, sf, nl, sl);
      check("o128_first_cnt", 64'(nf), 64'(2));
      check("o128_first_pos", 64'(sf), 64'(64));
      check("o128_last_cnt",  64'(nl), 64'(2));
      check("o128_last_pos",  64'(sl), 64'(190));
      check("o128_frames",    64'(frame_count), 64'(2));
      check("o128_err_gap",   64'(err_gap), 64'(0));
      @(posedge clock); #1;
      check("o128_valid_off", 64'(out_valid), 64'(0));

      // broken frame: 10 then gap
      drive_out(10, 16'h0200, nf, sf, nl, sl);
      repeat (3) @(posedge clock); #1;
      check("gap_err_set",  64'(err_gap), 64'(1));
      check("gap_frames",   64'(frame_count), 64'(2));
      drive_out(N, 16'h0300, nf, sf, nl, sl);
      check("gap_next_first_pos", 64'(nf*100 + sf), 64'(100));
      check("gap_next_last_pos",  64'(nl*100 + sl), 64'(163));
      check("gap_next_frames",    64'(frame_count), 64'(3));
      repeat (3) @(posedge clock); #1;
      check("gap_err_sticky",     64'(err_gap), 64'(1));

      // reset mid-burst after 30 samples
      for (int k = 0; k < N; k++) push_sample(W'(16'h7000 + k), W'(k), 0);
      in_valid = 1'b0;
      wait_rise("mr_rise", 20, rise);
      repeat (30) @(posedge clock); #1;
      check("mr_pre_di_en", 64'(di_en), 64'(1));
      reset = 1'b0;
      #1;
      check("mr_di_en",       64'(di_en),       64'(0));
      check("mr_in_ready",    64'(in_ready),    64'(1));
      check("mr_frame_count", 64'(frame_count), 64'(0));
      check("mr_err_gap",     64'(err_gap),     64'(0));
      repeat (2) @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      for (int k = 0; k < N; k++) push_sample(W'(16'h9000 + k), W'(16'h1111 + k), 0);
      in_valid = 1'b0;
      a_last = cyc;
      wait_rise("mr2_rise", 20, rise);
      check("mr2_latency",  64'(rise - a_last), 64'(2));
      check("mr2_first_re", 64'(di_re), 64'(16'h9000));
      burst_len(len);
      check("mr2_burst_len", 64'(len), 64'(N));
      repeat (5) @(posedge clock); #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
